// File: rtl/fib_pkg.sv
// fib_pkg: shared definitions for the Fibonacci pair serializer.
//
// Contents:
//   FIB_W        default width of one sequence value
//   FIB_DEPTH    default pair-FIFO capacity
//   fib_pair_t   one generator transfer: older value `num`, newer value `num2`
//   fib_sum()    next value of the recurrence, unsigned modulo 2^FIB_W
package fib_pkg;

    localparam int FIB_W     = 16;
    localparam int FIB_DEPTH = 4;

    typedef struct packed {
        logic [FIB_W-1:0] num;
        logic [FIB_W-1:0] num2;
    } fib_pair_t;

    // The recurrence wraps silently; there is no saturation or overflow flag.
    function automatic logic [FIB_W-1:0] fib_sum(input logic [FIB_W-1:0] a,
                                                 input logic [FIB_W-1:0] b);
        return a + b;
    endfunction

endpackage

// File: rtl/fib_pair_fifo.sv
// fib_pair_fifo: pair storage for fib_pair_serializer.
//
// Holds up to DEPTH pairs. Writes are registered; the head entry is read
// combinationally so a freshly pushed pair is visible the cycle after the push.
// Pointers carry one extra wrap bit so full and empty are told apart, and the
// occupancy is simply their difference.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-low reset (pointers only; storage is not reset)
//   push       write push_num/push_num2 at the write pointer (ignored when full)
//   push_num   older value of the incoming pair
//   push_num2  newer value of the incoming pair
//   pop        retire the head pair (ignored when empty)
//   head_num   older value of the head pair
//   head_num2  newer value of the head pair
//   level      number of pairs held
//   full       level == DEPTH
//   empty      level == 0
module fib_pair_fifo
    import fib_pkg::*;
#(
    parameter int W     = FIB_W,
    parameter int DEPTH = FIB_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [W-1:0]               push_num,
    input  logic [W-1:0]               push_num2,
    input  logic                       pop,
    output logic [W-1:0]               head_num,
    output logic [W-1:0]               head_num2,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

    logic [AW:0]    wr_ptr_reg, wr_ptr_next;
    logic [AW:0]    rd_ptr_reg, rd_ptr_next;
    logic           do_push;
    logic           do_pop;
    logic [2*W-1:0] mem [DEPTH];

    assign level = wr_ptr_reg - rd_ptr_reg;
    assign full  = (level == FULL_LEVEL);
    assign empty = (wr_ptr_reg == rd_ptr_reg);

    // Guard the strobes locally so a misbehaving caller cannot corrupt state.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        if (do_push) begin
            wr_ptr_next = wr_ptr_reg + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_next = rd_ptr_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
        end
    end

    // Storage entries, one write-enabled register per slot.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk) begin
            if (do_push && (wr_ptr_reg[AW-1:0] == AW'(gi))) begin
                mem[gi] <= {push_num2, push_num};
            end
        end
    end

    // Combinational head read: no extra pipeline stage on the output path.
    assign head_num  = mem[rd_ptr_reg[AW-1:0]][W-1:0];
    assign head_num2 = mem[rd_ptr_reg[AW-1:0]][2*W-1:W];

endmodule

// File: rtl/fib_pair_serializer.sv
// fib_pair_serializer: bridges a two-values-per-cycle Fibonacci generator to a
// one-value-per-cycle consumer.
//
// Each accepted pair (in_num, in_num2) is buffered in fib_pair_fifo and then
// emitted as two words, in_num first, in_num2 second. A `half` bit picks the
// word within the head pair; the pair is retired when its second word pops.
//
// Optional build macro: FIB_SER_SEQ_CHECK_EN adds a recurrence checker and the
// sticky seq_err output. Without it the port and logic are absent.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-low reset
//   in_valid   upstream pair valid
//   in_ready   a pair can be accepted (registered: !full)
//   in_num     older value of the pair
//   in_num2    newer value of the pair
//   out_valid  out_data holds a word (registered: !empty)
//   out_ready  consumer accepts the word
//   out_data   current word, 0 while out_valid is 0
//   level      pairs held, including a partially emitted one
//   seq_err    sticky recurrence violation (FIB_SER_SEQ_CHECK_EN only)
module fib_pair_serializer
    import fib_pkg::*;
#(
    parameter int W     = FIB_W,
    parameter int DEPTH = FIB_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [W-1:0]           in_num,
    input  logic [W-1:0]           in_num2,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [W-1:0]           out_data,
    output logic [$clog2(DEPTH):0] level
`ifdef FIB_SER_SEQ_CHECK_EN
    ,
    output logic                   seq_err
`endif
);

    logic         half_reg, half_next;
    logic         fifo_full;
    logic         fifo_empty;
    logic         push;
    logic         pop_word;
    logic         pop_pair;
    logic [W-1:0] head_num;
    logic [W-1:0] head_num2;

    // Both handshake outputs come straight from registered FIFO state, so a
    // completing pop never raises in_ready in the same cycle.
    assign in_ready  = !fifo_full;
    assign out_valid = !fifo_empty;

    assign push     = in_valid && in_ready;
    assign pop_word = out_valid && out_ready;
    // The pair only leaves the FIFO once its second word is consumed.
    assign pop_pair = pop_word && half_reg;

    fib_pair_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_num  (in_num),
        .push_num2 (in_num2),
        .pop       (pop_pair),
        .head_num  (head_num),
        .head_num2 (head_num2),
        .level     (level),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        half_next = half_reg;
        if (pop_word) begin
            half_next = !half_reg;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            half_reg <= 1'b0;
        end else begin
            half_reg <= half_next;
        end
    end

    always_comb begin
        out_data = '0;
        if (out_valid) begin
            out_data = half_reg ? head_num2 : head_num;
        end
    end

`ifdef FIB_SER_SEQ_CHECK_EN
    // Recurrence checker: a_reg is the older and b_reg the newer of the last
    // two emitted words; cnt_reg saturates at 2 once both are meaningful.
    logic [W-1:0] a_reg, a_next;
    logic [W-1:0] b_reg, b_next;
    logic [1:0]   cnt_reg, cnt_next;
    logic         seq_err_reg, seq_err_next;
    logic [W-1:0] expect_word;

    assign expect_word = a_reg + b_reg;

    always_comb begin
        a_next       = a_reg;
        b_next       = b_reg;
        cnt_next     = cnt_reg;
        seq_err_next = seq_err_reg;
        if (pop_word) begin
            if ((cnt_reg == 2'd2) && (out_data != expect_word)) begin
                seq_err_next = 1'b1;
            end
            a_next = b_reg;
            b_next = out_data;
            if (cnt_reg != 2'd2) begin
                cnt_next = cnt_reg + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_reg       <= '0;
            b_reg       <= '0;
            cnt_reg     <= '0;
            seq_err_reg <= 1'b0;
        end else begin
            a_reg       <= a_next;
            b_reg       <= b_next;
            cnt_reg     <= cnt_next;
            seq_err_reg <= seq_err_next;
        end
    end

    assign seq_err = seq_err_reg;
`endif

endmodule

// File: tb/tb_fib_pair_serializer.sv
// tb_fib_pair_serializer: randomized self-checking bench for fib_pair_serializer.
// The reference model is a word queue: each accepted pair appends two words,
// each consumed word removes the front. All visible outputs are derived from
// that queue every cycle.
module tb_fib_pair_serializer;
    import fib_pkg::*;

    localparam int W     = 16;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_num;
    logic [W-1:0]  in_num2;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [LW-1:0] level;
`ifdef FIB_SER_SEQ_CHECK_EN
    logic          seq_err;
`endif

    fib_pair_serializer #(
        .W     (W),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_num    (in_num),
        .in_num2   (in_num2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .level     (level)
`ifdef FIB_SER_SEQ_CHECK_EN
        ,
        .seq_err   (seq_err)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] q[$];     // words still owed by the DUT, oldest first
    logic [W-1:0] hist[$];  // words emitted since the last reset
    bit           exp_err;  // expected sticky recurrence flag

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic int model_level();
        return (q.size() + 1) / 2;
    endfunction

    function automatic logic [31:0] model_word();
        if (q.size() == 0) return 32'd0;
        return {16'd0, q[0]};
    endfunction

    task automatic model_reset();
        q.delete();
        hist.delete();
        exp_err = 1'b0;
    endtask

    // One clock cycle: compare every output at the negedge, drive the new
    // inputs, then advance the model across the following posedge.
    task automatic step(input bit v, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit ordy, output bit pushed);
        bit push_now;
        bit pop_now;
        logic [W-1:0] s;
        @(negedge clk);
        check_eq("in_ready", in_ready, model_level() < DEPTH);
        check_eq("out_valid", out_valid, q.size() != 0);
        check_eq("out_data", out_data, model_word());
        check_eq("level", level, model_level());
`ifdef FIB_SER_SEQ_CHECK_EN
        check_eq("seq_err", seq_err, exp_err);
`endif
        in_valid  = v;
        in_num    = a;
        in_num2   = b;
        out_ready = ordy;
        push_now  = v && (model_level() < DEPTH);
        pop_now   = ordy && (q.size() != 0);
        @(posedge clk);
        if (pop_now) begin
            hist.push_back(q[0]);
            if (hist.size() >= 3) begin
                s = hist[hist.size()-3] + hist[hist.size()-2];
                if (hist[hist.size()-1] != s) exp_err = 1'b1;
            end
            $display("pop  word=%0d", q[0]);
            void'(q.pop_front());
        end
        if (push_now) begin
            q.push_back(a);
            q.push_back(b);
            $display("push num=%0d num2=%0d", a, b);
        end
        pushed = push_now;
    endtask

    task automatic drain(input int budget);
        bit p;
        int n = 0;
        while (q.size() != 0 && n < budget) begin
            step(1'b0, '0, '0, 1'b1, p);
            n++;
        end
        check_eq("drain_done", q.size(), 0);
        step(1'b0, '0, '0, 1'b1, p);
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        bit p;
        int acc;
        logic [W-1:0] f0, f1;
        fib_pair_t pr;

        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_num = '0; in_num2 = '0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Reset state.
        @(negedge clk);
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_data", out_data, 0);
        check_eq("rst_level", level, 0);

        // Basic order followed by a mid-pair stall on (13,21).
        step(1'b1, 16'd1, 16'd1, 1'b1, p);
        step(1'b1, 16'd2, 16'd3, 1'b1, p);
        step(1'b1, 16'd5, 16'd8, 1'b1, p);
        drain(20);
        check_eq("basic_level_end", level, 0);
        step(1'b1, 16'd13, 16'd21, 1'b0, p);
        step(1'b1, 16'd34, 16'd55, 1'b1, p);  // first word 13 pops here
        repeat (3) begin
            step(1'b0, '0, '0, 1'b0, p);
            check_eq("stall_hold", out_data, 21);
        end
        drain(20);

        // Full: in_valid held 6 cycles with the consumer stalled.
        do_reset();
        acc = 0;
        f0 = 16'd1; f1 = 16'd1;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, f0, f1, 1'b0, p);
            if (p) begin
                acc++;
                f0 = f0 + f1; f1 = f0 + f1;
            end
        end
        step(1'b0, '0, '0, 1'b0, p);
        check_eq("full_accepted", acc, DEPTH);
        check_eq("full_level", level, DEPTH);
        check_eq("full_in_ready", in_ready, 0);
        drain(40);

        // Wrap-around with random flow control, pairs starting at F13 so the
        // stream crosses 28657, 46368, 9489 (75025 mod 2^16).
        do_reset();
        f0 = 16'd233; f1 = 16'd377;
        acc = 0;
        for (int i = 0; i < 400 && acc < 3*DEPTH; i++) begin
            pr.num = f0; pr.num2 = f1;
            step(1'($urandom_range(0, 1)), pr.num, pr.num2, 1'($urandom_range(0, 1)), p);
            if (p) begin
                acc++;
                f0 = f0 + f1; f1 = f0 + f1;
            end
        end
        check_eq("wrap_pairs", acc, 3*DEPTH);
        drain(60);
        check_eq("wrap_seq_ok", exp_err, 0);

        // Recurrence violation (1,1),(2,4).
        do_reset();
        step(1'b1, 16'd1, 16'd1, 1'b1, p);
        step(1'b1, 16'd2, 16'd4, 1'b1, p);
        drain(20);
        repeat (2) step(1'b0, '0, '0, 1'b0, p);
`ifdef FIB_SER_SEQ_CHECK_EN
        check_eq("seq_err_sticky", seq_err, 1);
`endif

        // Asynchronous reset with level=3 and half=1.
        do_reset();
        step(1'b1, 16'd1, 16'd1, 1'b0, p);
        step(1'b1, 16'd2, 16'd3, 1'b0, p);
        step(1'b1, 16'd5, 16'd8, 1'b0, p);
        step(1'b0, '0, '0, 1'b1, p);         // pop first word -> half=1
        @(negedge clk);
        check_eq("pre_rst_level", level, 3);
        check_eq("pre_rst_data", out_data, 1);
        out_ready = 1'b0;
        #2 rst = 1'b0;
        #1;
        check_eq("async_in_ready", in_ready, 1);
        check_eq("async_out_valid", out_valid, 0);
        check_eq("async_out_data", out_data, 0);
        check_eq("async_level", level, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        step(1'b1, 16'd1, 16'd1, 1'b1, p);
        drain(10);
        check_eq("post_rst_words", hist.size(), 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fib_pair_serializer.md
# fib_pair_serializer

Downstream stage of the double-rate Fibonacci generator. Each transfer accepts one pair of consecutive sequence values (`num`, `num2`) through a valid/ready handshake and buffers it in a small pair FIFO. The buffered values leave as a single-word-per-cycle stream, `num` first and then `num2`. The block bridges the generator's two-values-per-cycle rate down to a one-value-per-cycle consumer and applies backpressure when its buffer is full.

## Interface
- `W`, 16: data width of each sequence value.
- `DEPTH`, 4: FIFO capacity in pairs; a power of two, at least 2.
- `clk` input 1: the block's only clock; all logic is rising-edge.
- `rst` input 1: reset, asynchronous and active-low. Asserting it (low) resets everything immediately.
- `in_valid` input 1: the upstream pair is valid.
- `in_ready` output 1: the block can accept a pair. Equals `!full`.
- `in_num` input W: first (older) value of the pair.
- `in_num2` input W: second (newer) value of the pair.
- `out_valid` output 1: `out_data` holds a word. Equals `!empty`.
- `out_ready` input 1: the consumer accepts the word.
- `out_data` output W: the current output word; driven to 0 whenever `out_valid` is 0.
- `level` output $clog2(DEPTH)+1: number of pairs held, including a partially emitted pair.
- `seq_err` output 1: sticky recurrence-violation flag. Present only with `FIB_SER_SEQ_CHECK_EN`.

## Operation
- **Push.** A push occurs when `in_valid && in_ready`. The pair is written at `wr_ptr`, then `wr_ptr` and `level` increment.
- **Half select.** A `half` bit selects the output word: `out_data = half ? head.num2 : head.num`.
- **Pop.** A pop occurs when `out_valid && out_ready`.
  - If `half` is 0, `half` becomes 1.
  - If `half` is 1, `half` becomes 0, `rd_ptr` increments and `level` decrements.
- **Pointers.** Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Full/empty detection uses an extra wrap bit, or `level` directly.
- **Simultaneous push and completing pop.** `level` is unchanged and both pointers advance.
- **Push while full.** Not possible: `in_ready` is 0. A completing pop in the same cycle does not raise `in_ready` combinationally; there is no write-through.
- **Empty FIFO.** There is no bypass. `out_valid` stays 0 until the cycle after the push.
- **Stalled output.** While `out_valid && !out_ready`, `out_data` and `half` hold stable.
- **Arithmetic.** Values are treated as unsigned modulo 2^W; the block never saturates or flags overflow.

## Timing
- **Reset values:** `in_ready`=1, `out_valid`=0, `out_data`=0, `level`=0, `half`=0, both pointers 0, `seq_err`=0. FIFO storage is not reset.
- **Reset mid-operation.** All buffered pairs are discarded, including a partially emitted pair. After release the block is in the reset state.
- **Latency.** A push at edge N makes `out_valid` 1 after edge N, so the first word is visible in cycle N+1. It comes out of the storage read path; there is no extra register stage.
- **Throughput.** The output runs at 1 word/cycle, which is 1 pair per 2 cycles. A continuous upstream at 1 pair/cycle sees `in_ready` drop once the FIFO fills.
- **Handshake rules.** `in_ready` and `out_valid` depend only on registered state, never combinationally on `in_valid` or `out_ready`.

## Configuration
- **`FIB_SER_SEQ_CHECK_EN` defined:**
  - The checker registers the last two emitted words (`a`, `b`) and a 2-bit saturating count of emitted words.
  - On each pop with count==2: if `out_data != (a + b) mod 2^W`, `seq_err` is set.
  - `seq_err` clears only on reset.
- **`FIB_SER_SEQ_CHECK_EN` undefined:** the `seq_err` port and all checker logic are absent.

## Structure
- **Package `fib_pkg`:** holds `FIB_W` = 16 and `typedef struct packed { logic [FIB_W-1:0] num, num2; } fib_pair_t`.
- **Sub-module `fib_pair_fifo`:**
  - Contains the storage, pointers, `level` and full/empty.
  - Has push/pop ports and a combinational head read.
- **Top level:** contains `half`, output muxing and the checker.

## Test plan
- **Basic order.** After reset, push (1,1), (2,3), (5,8) on consecutive cycles with `out_ready`=1 → `out_data` = 1,1,2,3,5,8 on consecutive cycles starting the cycle after the first push. `level` ends at 0. `seq_err` stays 0.
- **Full.** DEPTH=4, `out_ready`=0, `in_valid` held for 6 cycles → exactly 4 pairs accepted, `in_ready`=0 from the cycle after the 4th push, `level`=4. Raising `out_ready` drains all 8 words in order, and `in_ready` returns 1 the cycle after the first completing pop.
- **Mid-pair stall.** Hold `out_ready`=0 after the first word of (13,21) → `out_data`=21 holds stable for 3 cycles, then pops. The next pair's `num` follows immediately.
- **Wrap-around and modulo arithmetic.** Stream 3×DEPTH generator pairs, including 28657, 46368, 9489 (75025 mod 2^16), with `out_ready` toggling randomly → order preserved across pointer wrap. `seq_err` stays 0.
- **Checker.** With `FIB_SER_SEQ_CHECK_EN` defined, push (1,1),(2,4) → `seq_err` rises the cycle after word 4 pops and remains 1 until reset.
- **Reset mid-operation.** Assert `rst` low asynchronously with `level`=3 and `half`=1 → outputs reach reset values without a clock edge. After release, a new push (1,1) emits 1,1.
